// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
//   Initiator-side controller for the single-port RAM protocol. It arbitrates
//   round-robin between an instruction-fetch requester (I) and a data
//   requester (D). It drives one RAM request at a time and holds it until the
//   RAM reports ACCESS. A watchdog aborts a grant that never completes.
//
// Ports
//   CLK, nRST              clock (rising edge), async active-low reset
//   iREN/iaddr             instruction read request and word address
//   iwait/iload            I stall flag and read data
//   dREN/dWEN/daddr/dstore data read/write request, address and write data
//   dwait/dload            D stall flag and read data
//   ramREN/ramWEN          RAM read/write enables (never both high)
//   ramaddr/ramstore       RAM address and write data
//   ramload/ramstate       RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err                    sticky timeout flag
module mem_req_ctrl #(
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] BADWORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  // last-grant encoding: 0 = I, 1 = D
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic i_req, d_req, i_act, d_act, access, tmo, i_done, d_done;

  // Outputs are gated by the registered state but follow the request inputs
  // combinationally. A withdrawn request therefore drops off the RAM bus in
  // the same cycle, and an async reset clears the outputs at once.
  always_comb begin
    i_req  = iREN;
    d_req  = dREN | dWEN;
    i_act  = (state_q == GNT_I) & i_req;
    d_act  = (state_q == GNT_D) & d_req;
    access = (ramstate == ST_ACCESS);
    tmo    = (cnt_q == CW'(TIMEOUT - 1));
    i_done = i_act & (access | tmo);
    d_done = d_act & (access | tmo);

    // dWEN wins over dREN so both enables are never driven together
    ramREN   = i_act | (d_act & ~dWEN);
    ramWEN   = d_act & dWEN;
    ramaddr  = i_act ? iaddr : (d_act ? daddr : 32'h0);
    ramstore = d_act ? dstore : 32'h0;

    iwait = i_req & ~i_done;
    dwait = d_req & ~d_done;
    iload = i_done ? (access ? ramload : BADWORD) : 32'h0;
    dload = d_done ? (access ? ramload : BADWORD) : 32'h0;
    err   = err_q;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_req && d_req) begin
          state_d = (last_q == LAST_I) ? GNT_D : GNT_I;
          last_d  = (last_q == LAST_I) ? LAST_D : LAST_I;
        end else if (d_req) begin
          state_d = GNT_D;
          last_d  = LAST_D;
        end else if (i_req) begin
          state_d = GNT_I;
          last_d  = LAST_I;
        end
      end
      GNT_I, GNT_D: begin
        // withdrawal, completion or abort all return through IDLE, which
        // also gives the RAM a FREE cycle before the next grant
        if (!(i_act || d_act) || i_done || d_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if ((i_act || d_act) && !access && tmo) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      last_q  <= LAST_I;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl
//   Directed bench for mem_req_ctrl with TIMEOUT=8. Inputs change 1ns after
//   each rising edge and outputs are sampled 1ns later, well clear of the edge.
module tb_mem_req_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  int total = 0;
  int bad   = 0;

  mem_req_ctrl #(.TIMEOUT(8), .BADWORD(32'hBAD1BAD1)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // ---- reset state
    #2;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iwait_noreq", iwait, 0);
    chk("rst_err", err, 0);
    iREN = 1'b1; #1;
    chk("rst_iwait_req", iwait, 1);
    iREN = 1'b0;
    tick(); tick();
    nRST = 1'b1;

    // ---- I-only read, ACCESS on the 3rd granted cycle
    tick();
    iREN = 1'b1; iaddr = 32'h40; #1;
    chk("i_idle_ramREN", ramREN, 0);
    chk("i_idle_iwait", iwait, 1);
    tick(); ramstate = BUSY; #1;
    chk("i_g1_ramREN", ramREN, 1);
    chk("i_g1_ramaddr", ramaddr, 32'h40);
    chk("i_g1_iwait", iwait, 1);
    chk("i_g1_iload", iload, 0);
    tick(); #1;
    chk("i_g2_iwait", iwait, 1);
    tick(); ramstate = ACC; ramload = 32'h8C010004; #1;
    chk("i_g3_iwait", iwait, 0);
    chk("i_g3_iload", iload, 32'h8C010004);
    tick(); iREN = 1'b0; ramstate = FREE; #1;
    chk("i_done_ramREN", ramREN, 0);
    chk("i_done_iload", iload, 0);

    // ---- D write while I pending (last grant was I, so D wins)
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    iREN = 1'b1; iaddr = 32'h44; #1;
    chk("dw_idle_ramWEN", ramWEN, 0);
    tick(); ramstate = BUSY; #1;
    chk("dw_g1_ramWEN", ramWEN, 1);
    chk("dw_g1_ramREN", ramREN, 0);
    chk("dw_g1_ramaddr", ramaddr, 32'h100);
    chk("dw_g1_ramstore", ramstore, 32'hDEADBEEF);
    chk("dw_g1_dwait", dwait, 1);
    tick(); ramstate = ACC; #1;
    chk("dw_acc_dwait", dwait, 0);
    chk("dw_acc_iwait", iwait, 1);
    tick(); dWEN = 1'b0; ramstate = FREE; #1;
    chk("dw_bubble_ramREN", ramREN, 0);
    chk("dw_bubble_iwait", iwait, 1);
    tick(); ramstate = ACC; ramload = 32'h11112222; #1;
    chk("dw_i_ramaddr", ramaddr, 32'h44);
    chk("dw_i_iwait", iwait, 0);
    chk("dw_i_iload", iload, 32'h11112222);
    tick(); iREN = 1'b0; ramstate = FREE; #1;

    // ---- contention with dREN=dWEN=1: D, I, D alternation
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; dWEN = 1'b1;
    daddr = 32'h104; dstore = 32'h5A5A5A5A; ramstate = ACC; ramload = 32'h33334444;
    tick(); #1;
    chk("ct_d1_ramWEN", ramWEN, 1);
    chk("ct_d1_ramREN", ramREN, 0);
    chk("ct_d1_dwait", dwait, 0);
    chk("ct_d1_iwait", iwait, 1);
    tick(); #1;
    chk("ct_bub_ramWEN", ramWEN, 0);
    chk("ct_bub_ramREN", ramREN, 0);
    chk("ct_bub_dwait", dwait, 1);
    tick(); #1;
    chk("ct_i_ramREN", ramREN, 1);
    chk("ct_i_ramWEN", ramWEN, 0);
    chk("ct_i_ramaddr", ramaddr, 32'h80);
    chk("ct_i_iload", iload, 32'h33334444);
    chk("ct_i_dwait", dwait, 1);
    tick(); #1;
    chk("ct_bub2_ramREN", ramREN, 0);
    tick(); #1;
    chk("ct_d2_ramWEN", ramWEN, 1);
    chk("ct_d2_ramaddr", ramaddr, 32'h104);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    tick(); #1;

    // ---- timeout: RAM reports ERROR forever, abort on 8th granted cycle
    dREN = 1'b1; daddr = 32'h200; ramstate = ERR;
    tick(); #1;
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("to_g%0d_dwait", k), dwait, 1);
      chk($sformatf("to_g%0d_err", k), err, 0);
      tick(); #1;
    end
    chk("to_g8_dwait", dwait, 0);
    chk("to_g8_dload", dload, 32'hBAD1BAD1);
    tick(); dREN = 1'b0; ramstate = FREE; #1;
    chk("to_after_err", err, 1);
    chk("to_after_ramREN", ramREN, 0);
    iREN = 1'b1; iaddr = 32'h48;
    tick(); ramstate = ACC; ramload = 32'h55556666; #1;
    chk("to_ok_iload", iload, 32'h55556666);
    chk("to_ok_err", err, 1);
    tick(); iREN = 1'b0; ramstate = FREE; #1;
    chk("to_sticky_err", err, 1);

    // ---- withdrawal mid-grant
    dREN = 1'b1; daddr = 32'h300;
    tick(); ramstate = BUSY; #1;
    chk("wd_g_ramREN", ramREN, 1);
    dREN = 1'b0; #1;
    chk("wd_drop_ramREN", ramREN, 0);
    chk("wd_drop_dwait", dwait, 0);
    chk("wd_drop_dload", dload, 0);
    tick(); ramstate = FREE; #1;
    chk("wd_err_kept", err, 1);

    // ---- async reset mid-grant, then a clean request
    iREN = 1'b1; iaddr = 32'h4C;
    tick(); ramstate = BUSY; #1;
    chk("rs_g_ramREN", ramREN, 1);
    nRST = 1'b0; ramstate = ACC; ramload = 32'hCAFEF00D; #1;
    chk("rs_async_ramREN", ramREN, 0);
    chk("rs_async_iwait", iwait, 1);
    chk("rs_async_iload", iload, 0);
    chk("rs_async_err", err, 0);
    tick(); nRST = 1'b1; #1;
    chk("rs_rel_ramREN", ramREN, 0);
    tick(); #1;
    chk("rs_new_ramREN", ramREN, 1);
    chk("rs_new_iwait", iwait, 0);
    chk("rs_new_iload", iload, 32'hCAFEF00D);
    chk("rs_new_err", err, 0);
    tick(); iREN = 1'b0; ramstate = FREE; #1;
    chk("rs_end_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
